fifo_prbs_checker: RTL and testbench

Synthesizable downstream checker for the synchronous FIFO: consumes `dout`/`valid` from the FIFO read side and compares every beat against a locally regenerated PRBS sequence, so no copy of sent data is stored. A matching upstream generator seeded identically drives `din`. The checker runs one test of a programmed length per `start` pulse and reports pass/fail, match and error counts, and details of the first mismatch.

---
 rtl/fifo_prbs_checker.sv | 208 ++++++++++++++++++++
 tb/tb_fifo_prbs_checker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_prbs_checker.sv
// fifo_prbs_checker
//
// Checks data coming out of the read side of a synchronous FIFO. Instead of
// storing a copy of the data that was sent, it regenerates the same PRBS
// sequence the upstream generator used (32-bit Fibonacci LFSR,
// x^32+x^22+x^2+x+1) and compares each valid beat against it. One test of a
// programmed length runs per start pulse. The result is reported as
// pass/fail, match and error counts, and the details of the first mismatch.
//
// Ports
//   clk           : single clock, all logic on the rising edge
//   rst_n         : asynchronous active-low reset
//   start         : one-cycle pulse, begins a test from IDLE or DONE
//   seed          : LFSR seed, sampled on an accepted start (0 acts as 1)
//   num_words     : number of beats to check, sampled on an accepted start
//   dout, valid   : FIFO read data and its qualifier
//   busy          : high while a test is running
//   done          : high once the test has finished; status is final
//   pass          : in DONE, no mismatches and no overrun
//   match_cnt     : beats that matched
//   err_cnt       : beats that mismatched (saturating)
//   overrun       : sticky, a valid beat arrived while in DONE
//   first_err_idx : beat index of the first mismatch
//   first_err_exp : expected value at the first mismatch
//   first_err_got : received value at the first mismatch

module fifo_prbs_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           seed,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  match_q, match_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [CNT_WIDTH-1:0]  fe_idx_q, fe_idx_d;
  logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;
  logic [DATA_WIDTH-1:0] fe_got_q, fe_got_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  overrun_q, overrun_d;

  logic [31:0]           lfsr_next;
  logic [31:0]           seed_eff;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  hit;
  logic                  last_beat;
  logic [CNT_WIDTH-1:0]  err_inc;

  assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  // An all-zero LFSR would lock up, so a zero seed is treated as 1.
  assign seed_eff  = (seed == 32'd0) ? 32'd1 : seed;
  assign exp_word  = lfsr_q[DATA_WIDTH-1:0];
  assign hit       = (dout == exp_word);
  // num_q is never zero in RUN; a zero-length test goes straight to DONE.
  assign last_beat = (idx_q == (num_q - CNT_ONE));
  assign err_inc   = (&err_q) ? err_q : (err_q + CNT_ONE);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    num_d     = num_q;
    match_d   = match_q;
    err_d     = err_q;
    fe_idx_d  = fe_idx_q;
    fe_exp_d  = fe_exp_q;
    fe_got_d  = fe_got_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // start takes priority over a coinciding valid beat in DONE.
          lfsr_d    = seed_eff;
          idx_d     = '0;
          num_d     = num_words;
          match_d   = '0;
          err_d     = '0;
          fe_idx_d  = '0;
          fe_exp_d  = '0;
          fe_got_d  = '0;
          overrun_d = 1'b0;
          if (num_words == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end else if ((state_q == DONE) && valid) begin
          overrun_d = 1'b1;
          pass_d    = 1'b0;
        end
      end

      RUN: begin
        if (valid) begin
          lfsr_d = lfsr_next;
          idx_d  = idx_q + CNT_ONE;
          if (hit) begin
            match_d = match_q + CNT_ONE;
          end else begin
            err_d = err_inc;
            // err_q saturates at all-ones, so zero reliably means no
            // mismatch has been seen yet in this test.
            if (err_q == '0) begin
              fe_idx_d = idx_q;
              fe_exp_d = exp_word;
              fe_got_d = dout;
            end
          end
          if (last_beat) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = hit && (err_q == '0);
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= 32'd1;
      idx_q     <= '0;
      num_q     <= '0;
      match_q   <= '0;
      err_q     <= '0;
      fe_idx_q  <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      match_q   <= match_d;
      err_q     <= err_d;
      fe_idx_q  <= fe_idx_d;
      fe_exp_q  <= fe_exp_d;
      fe_got_q  <= fe_got_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign match_cnt     = match_q;
  assign err_cnt       = err_q;
  assign overrun       = overrun_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_got = fe_got_q;

endmodule

// File: tb/tb_fifo_prbs_checker.sv
// Testbench for fifo_prbs_checker. A queue-based behavioural model is
// compared against the DUT on every clock. Directed scenarios pin the model
// to hand-computed values, and randomized runs follow them.

module tb_fifo_prbs_checker;

  localparam int DW = 8;
  localparam int CW = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [31:0]   seed;
  logic [CW-1:0] num_words;
  logic [DW-1:0] dout;
  logic          valid;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] err_cnt;
  logic          overrun;
  logic [CW-1:0] first_err_idx;
  logic [DW-1:0] first_err_exp;
  logic [DW-1:0] first_err_got;

  int tests;
  int fails;

  // Behavioural model state
  int            mMode;
  logic [DW-1:0] expQ[$];
  int            mIdx;
  int            mMatch;
  int            mErr;
  bit            mSeenErr;
  bit            mOverrun;
  bit            mPass;
  int            mFeIdx;
  logic [DW-1:0] mFeExp;
  logic [DW-1:0] mFeGot;

  fifo_prbs_checker #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .num_words    (num_words),
    .dout         (dout),
    .valid        (valid),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .match_cnt    (match_cnt),
    .err_cnt      (err_cnt),
    .overrun      (overrun),
    .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp),
    .first_err_got(first_err_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] nextLfsr(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs on the falling edge.
  task automatic applyStimulus(input logic s, input logic [31:0] sd,
                               input logic [CW-1:0] nw, input logic v,
                               input logic [DW-1:0] d);
    @(negedge clk);
    start     = s;
    seed      = sd;
    num_words = nw;
    valid     = v;
    dout      = d;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'd0, '0, 1'b0, '0);
  endtask

  task automatic beat(input logic [DW-1:0] d);
    applyStimulus(1'b0, 32'd0, '0, 1'b1, d);
  endtask

  task automatic modelReset();
    mMode    = M_IDLE;
    expQ.delete();
    mIdx     = 0;
    mMatch   = 0;
    mErr     = 0;
    mSeenErr = 0;
    mOverrun = 0;
    mPass    = 0;
    mFeIdx   = 0;
    mFeExp   = '0;
    mFeGot   = '0;
  endtask

  // The model lists the whole expected sequence up front at start and
  // consumes it one valid beat at a time; the test ends when it runs dry.
  task automatic modelStep();
    logic [31:0]   g;
    logic [DW-1:0] e;
    if (mMode != M_RUN) begin
      if (start) begin
        expQ.delete();
        g = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < int'(num_words); i++) begin
          expQ.push_back(g[DW-1:0]);
          g = nextLfsr(g);
        end
        mIdx = 0; mMatch = 0; mErr = 0; mSeenErr = 0; mOverrun = 0;
        mFeIdx = 0; mFeExp = '0; mFeGot = '0;
        if (expQ.size() == 0) begin
          mMode = M_DONE;
          mPass = 1;
        end else begin
          mMode = M_RUN;
          mPass = 0;
        end
      end else if (mMode == M_DONE && valid) begin
        mOverrun = 1;
        mPass    = 0;
      end
    end else if (valid) begin
      e = expQ.pop_front();
      if (dout == e) begin
        mMatch++;
      end else begin
        if (!mSeenErr) begin
          mSeenErr = 1;
          mFeIdx   = mIdx;
          mFeExp   = e;
          mFeGot   = dout;
        end
        if (mErr < (2 ** CW) - 1) mErr++;
      end
      mIdx++;
      if (expQ.size() == 0) begin
        mMode = M_DONE;
        mPass = (mErr == 0);
      end
    end
  endtask

  // Advances the model on each rising edge and checks every output shortly
  // after the edge.
  always @(posedge clk) begin
    if (!rst_n) modelReset();
    else        modelStep();
    #1;
    checkOutput("busy",          32'(busy),          32'(mMode == M_RUN));
    checkOutput("done",          32'(done),          32'(mMode == M_DONE));
    checkOutput("pass",          32'(pass),          32'(mPass));
    checkOutput("match_cnt",     32'(match_cnt),     32'(mMatch));
    checkOutput("err_cnt",       32'(err_cnt),       32'(mErr));
    checkOutput("overrun",       32'(overrun),       32'(mOverrun));
    checkOutput("first_err_idx", 32'(first_err_idx), 32'(mFeIdx));
    checkOutput("first_err_exp", 32'(first_err_exp), 32'(mFeExp));
    checkOutput("first_err_got", 32'(first_err_got), 32'(mFeGot));
  end

  task automatic checkFinal(input string tag, input logic expDone,
                            input logic expPass, input int expMatch,
                            input int expErr);
    checkOutput({tag, "_done"},  32'(done),      32'(expDone));
    checkOutput({tag, "_pass"},  32'(pass),      32'(expPass));
    checkOutput({tag, "_match"}, 32'(match_cnt), 32'(expMatch));
    checkOutput({tag, "_err"},   32'(err_cnt),   32'(expErr));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"},    32'(busy),          32'd0);
    checkOutput({tag, "_done"},    32'(done),          32'd0);
    checkOutput({tag, "_pass"},    32'(pass),          32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun),       32'd0);
    checkOutput({tag, "_match"},   32'(match_cnt),     32'd0);
    checkOutput({tag, "_err"},     32'(err_cnt),       32'd0);
    checkOutput({tag, "_fe_idx"},  32'(first_err_idx), 32'd0);
    checkOutput({tag, "_fe_exp"},  32'(first_err_exp), 32'd0);
    checkOutput({tag, "_fe_got"},  32'(first_err_got), 32'd0);
  endtask

  initial begin
    logic [31:0]   sd;
    logic [31:0]   g;
    logic [DW-1:0] d;
    int            nw;
    int            k;
    int            guard;

    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    seed      = 32'd0;
    num_words = '0;
    valid     = 1'b0;
    dout      = '0;
    modelReset();

    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Seed 1, four matching beats back-to-back.
    applyStimulus(1'b1, 32'd1, 16'd4, 1'b0, 8'h00);
    beat(8'h01); beat(8'h03); beat(8'h06); beat(8'h0D);
    idleCycle();
    checkFinal("t1", 1'b1, 1'b1, 4, 0);

    // Third beat corrupted.
    applyStimulus(1'b1, 32'd1, 16'd4, 1'b0, 8'h00);
    beat(8'h01); beat(8'h03); beat(8'h07); beat(8'h0D);
    idleCycle();
    checkFinal("t2", 1'b1, 1'b0, 3, 1);
    checkOutput("t2_fe_idx", 32'(first_err_idx), 32'd2);
    checkOutput("t2_fe_exp", 32'(first_err_exp), 32'h06);
    checkOutput("t2_fe_got", 32'(first_err_got), 32'h07);

    // Beats separated by three idle cycles.
    applyStimulus(1'b1, 32'd1, 16'd4, 1'b0, 8'h00);
    beat(8'h01); repeat (3) idleCycle();
    beat(8'h03); repeat (3) idleCycle();
    checkOutput("t3_busy_mid", 32'(busy), 32'd1);
    beat(8'h06); repeat (3) idleCycle();
    beat(8'h0D);
    idleCycle();
    checkFinal("t3", 1'b1, 1'b1, 4, 0);

    // Zero-length test, then an overrun beat.
    applyStimulus(1'b1, 32'd1, 16'd0, 1'b0, 8'h00);
    idleCycle();
    checkFinal("t4", 1'b1, 1'b1, 0, 0);
    beat(8'h55);
    idleCycle();
    checkOutput("t4_overrun", 32'(overrun), 32'd1);
    checkOutput("t4_pass_after_overrun", 32'(pass), 32'd0);

    // Seed 0 behaves as seed 1; start with a coinciding valid in DONE.
    applyStimulus(1'b1, 32'd0, 16'd4, 1'b1, 8'hAA);
    beat(8'h01); beat(8'h03); beat(8'h06); beat(8'h0D);
    idleCycle();
    checkFinal("t5", 1'b1, 1'b1, 4, 0);
    checkOutput("t5_overrun", 32'(overrun), 32'd0);

    // Reset after two beats of a four-beat run, then a clean restart.
    applyStimulus(1'b1, 32'd1, 16'd4, 1'b0, 8'h00);
    beat(8'h01); beat(8'h03);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkResetValues("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'd1, 16'd4, 1'b0, 8'h00);
    beat(8'h01); beat(8'h03); beat(8'h06); beat(8'h0D);
    idleCycle();
    checkFinal("t6", 1'b1, 1'b1, 4, 0);

    // Randomized runs: random seeds and lengths, gaps, corrupted beats,
    // ignored starts during RUN, overrun beats and start+valid in DONE.
    for (int r = 0; r < 40; r++) begin
      sd = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      nw = $urandom_range(1, 24);
      applyStimulus(1'b1, sd, CW'(nw), 1'($urandom_range(0, 1)), DW'($urandom));
      g     = (sd == 32'd0) ? 32'd1 : sd;
      k     = 0;
      guard = 0;
      while (k < nw && guard < 400) begin
        guard++;
        if ($urandom_range(0, 3) != 0) begin
          d = g[DW-1:0];
          if ($urandom_range(0, 5) == 0) d = d ^ DW'($urandom_range(1, 255));
          applyStimulus(1'($urandom_range(0, 9) == 0), $urandom, CW'($urandom),
                        1'b1, d);
          g = nextLfsr(g);
          k++;
        end else begin
          applyStimulus(1'($urandom_range(0, 9) == 0), $urandom, CW'($urandom),
                        1'b0, DW'($urandom));
        end
      end
      repeat ($urandom_range(1, 3))
        applyStimulus(1'b0, 32'd0, '0, 1'($urandom_range(0, 2) == 0), DW'($urandom));
    end

    idleCycle();
    idleCycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
